mult_div_unit: RTL and testbench

- Sequenced HI/LO multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse from the E-stage controller and models fixed multi-cycle latency with a down-counter.
- Exposes busy to the hazard/stall logic, and exposes architectural HI/LO for MFHI/MFLO forwarding into the E-stage ALU output mux.

---
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage: one command per start pulse,
// fixed multi-cycle latency, results committed to HI/LO when the count expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        busy_or_start,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic        commit_q, commit_d;

  md_op_e      op;
  state_e      state;
  logic        mul_signed, div_signed;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign op    = md_op_e'(md_op);
  assign state = (count_q != 4'd0) ? ST_BUSY : ST_IDLE;

  // Signed arithmetic is done on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    mul_signed = (op == OP_MULT);
    div_signed = (op == OP_DIV);
    a_ext   = {{32{mul_signed & src_a[31]}}, src_a};
    b_ext   = {{32{mul_signed & src_b[31]}}, src_b};
    product = a_ext * b_ext;
    a_mag   = (div_signed & src_a[31]) ? -src_a : src_a;
    b_mag   = (div_signed & src_b[31]) ? -src_b : src_b;
    b_safe  = (src_b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quot    = (div_signed & (src_a[31] ^ src_b[31])) ? -q_mag : q_mag;
    rem     = (div_signed & src_a[31]) ? -r_mag : r_mag;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    commit_d = commit_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              count_d  = MULT_N;
              hi_tmp_d = product[63:32];
              lo_tmp_d = product[31:0];
              commit_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              count_d  = DIV_N;
              hi_tmp_d = rem;
              lo_tmp_d = quot;
              commit_d = (src_b != 32'd0);
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        count_d = count_q - 4'd1;
        // Divide by zero still burns the full latency but leaves HI/LO alone.
        if (count_q == 4'd1 && commit_q) begin
          hi_d = hi_tmp_q;
          lo_d = lo_tmp_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      commit_q <= commit_d;
    end
  end

  assign busy          = (state == ST_BUSY);
  assign busy_or_start = busy | start;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO and busy
// length per operation; a negedge monitor checks each completion.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, busy_or_start;
  logic [31:0] hi, lo;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .busy_or_start(busy_or_start),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] old_hi, old_lo, new_hi, new_lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          proto_cnt = 0;
  logic        bos_watch = 1'b0;
  logic        bos_bad = 1'b0;
  logic [31:0] model_hi, model_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_op(input string name, input logic [31:0] nh, input logic [31:0] nl,
                           input int len);
    exp_t e;
    e.name = name; e.old_hi = model_hi; e.old_lo = model_lo;
    e.new_hi = nh; e.new_lo = nl; e.len = len;
    sb_q.push_back(e);
    model_hi = nh;
    model_lo = nl;
  endtask

  task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    issue_now(op, a, b);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Monitor: counts busy cycles and scores each operation when busy falls.
  initial begin
    int   busy_cnt = 0;
    logic hold_bad = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        hold_bad = 1'b0;
      end else begin
        if (start && busy) proto_cnt++;
        if (bos_watch && !busy_or_start) bos_bad = 1'b1;
        if (busy) begin
          busy_cnt++;
          if (sb_q.size() > 0 && (hi !== sb_q[0].old_hi || lo !== sb_q[0].old_lo))
            hold_bad = 1'b1;
        end else if (busy_cnt > 0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_hi"}, 64'(hi), 64'(e.new_hi));
            check({e.name, "_lo"}, 64'(lo), 64'(e.new_lo));
            check({e.name, "_busy_len"}, 64'(busy_cnt), 64'(e.len));
            check({e.name, "_hold"}, 64'(hold_bad), 64'd0);
          end
          busy_cnt = 0;
          hold_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_bos", 64'(busy_or_start), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    // 1-3: multiply and divide results
    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult");
    expect_op("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");
    expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");
    expect_op("divu", 32'd1, 32'd3, 10);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle("divu");
    expect_op("div_ovf", 32'd0, 32'h8000_0000, 10);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    // 4: MTHI is single-cycle, then divide by zero leaves HI/LO unchanged
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    model_hi = 32'h1234_5678;
    expect_op("divu_by0", model_hi, model_lo, 10);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle("divu_by0");

    // reserved opcode does nothing
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("rsv_busy", 64'(busy), 64'd0);
    check("rsv_hi", 64'(hi), 64'(model_hi));
    check("rsv_lo", 64'(lo), 64'(model_lo));

    // 5: MTLO while busy is ignored; async reset mid-operation
    expect_op("mult_killed", 32'd0, 32'd12, 5);
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    issue_now(3'd5, 32'h0000_AAAA, 32'd0);
    check("mtlo_ignored_lo", 64'(lo), 64'h8000_0000);
    check("mtlo_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    sb_q.delete();
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    saw_busy = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    check("post_rst_no_busy", 64'(saw_busy), 64'd0);
    check("post_rst_hi", 64'(hi), 64'd0);
    check("post_rst_lo", 64'(lo), 64'd0);

    // 6: back-to-back MULT then DIVU in the cycle busy falls
    bos_bad = 1'b0;
    @(posedge clk); #1;
    bos_watch = 1'b1;
    expect_op("b2b_mult", 32'd0, 32'd42, 5);
    issue_now(3'd0, 32'd6, 32'd7);
    wait_idle("b2b_mult");
    expect_op("b2b_divu", 32'd2, 32'd14, 10);
    issue_now(3'd3, 32'd100, 32'd7);
    check("b2b_busy_reassert", 64'(busy), 64'd1);
    wait_idle("b2b_divu");
    bos_watch = 1'b0;
    check("b2b_bos_continuous", 64'(bos_bad), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("protocol_violations", 64'(proto_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
